// File: rtl/dm_ctrl.sv
// Data-memory controller: registers core loads/stores, stalls until mem_ack, steers lanes, extends loads.
// Define DM_RMW_EN for memories without byte enables: sub-word stores become read-modify-write.
module dm_ctrl #(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [2:0]    cpu_dmtype,
    input  logic [AW-1:0] cpu_addr,
    input  logic [31:0]   cpu_wdata,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_stall,
    output logic          cpu_misalign,
    output logic          mem_req,
    output logic          mem_we,
    output logic [3:0]    mem_be,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    input  logic          mem_ack
);

`ifdef DM_RMW_EN
    typedef enum logic [2:0] {IDLE, RD, WR, DONE, RMW_RD, RMW_WR} state_t;
`else
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
`endif

    state_t        state_q, state_d;
    logic          req_q, req_d;
    logic          accept, capture_word;
    logic [2:0]    dmtype_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q, word_q;
    logic          misalign_q;

    logic       in_half, in_byte, in_misalign;
    logic       q_half, q_byte;
    logic [3:0] lane_be;
    logic [31:0] steer_wdata, merged_wdata, load_ext;
    logic [7:0]  load_byte;
    logic [15:0] load_half;

    assign in_half     = (cpu_dmtype == 3'b001) || (cpu_dmtype == 3'b010);
    assign in_byte     = (cpu_dmtype == 3'b011) || (cpu_dmtype == 3'b100);
    assign in_misalign = in_half ? cpu_addr[0] : (!in_byte && (cpu_addr[1:0] != 2'b00));

    assign q_half = (dmtype_q == 3'b001) || (dmtype_q == 3'b010);
    assign q_byte = (dmtype_q == 3'b011) || (dmtype_q == 3'b100);

    assign lane_be     = q_byte ? (4'b0001 << addr_q[1:0])
                       : q_half ? (addr_q[1] ? 4'b1100 : 4'b0011)
                       : 4'b1111;
    assign steer_wdata = q_byte ? {4{wdata_q[7:0]}}
                       : q_half ? {2{wdata_q[15:0]}}
                       : wdata_q;

    // Lanes outside the store keep the word read back; only used by the RMW write.
    always_comb begin
        merged_wdata = word_q;
        for (int k = 0; k < 4; k++) begin
            if (lane_be[k]) merged_wdata[8*k +: 8] = steer_wdata[8*k +: 8];
        end
    end

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        req_d        = 1'b0;
        accept       = 1'b0;
        capture_word = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    accept = 1'b1;
                    if (in_misalign) begin
                        state_d = DONE;
                    end else if (!cpu_we) begin
                        state_d = RD;
                        req_d   = 1'b1;
`ifdef DM_RMW_EN
                    end else if (in_byte || in_half) begin
                        state_d = RMW_RD;
                        req_d   = 1'b1;
`endif
                    end else begin
                        state_d = WR;
                        req_d   = 1'b1;
                    end
                end
            end
            RD, WR: begin
                req_d = 1'b1;
                if (req_q && mem_ack) begin
                    capture_word = (state_q == RD);
                    state_d      = DONE;
                    req_d        = 1'b0;
                end
            end
`ifdef DM_RMW_EN
            // mem_req drops for one cycle between the read and the write so the two
            // handshakes stay distinct; RMW_WR raises it again from its second cycle.
            RMW_RD: begin
                req_d = 1'b1;
                if (req_q && mem_ack) begin
                    capture_word = 1'b1;
                    state_d      = RMW_WR;
                    req_d        = 1'b0;
                end
            end
            RMW_WR: begin
                req_d = 1'b1;
                if (req_q && mem_ack) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; the async reset drops mem_req at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            dmtype_q   <= 3'b000;
            addr_q     <= '0;
            wdata_q    <= '0;
            word_q     <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            if (accept) begin
                dmtype_q   <= cpu_dmtype;
                addr_q     <= cpu_addr;
                wdata_q    <= cpu_wdata;
                misalign_q <= in_misalign;
            end
            if (capture_word) word_q <= mem_rdata;
        end
    end

    always_comb begin
        case (addr_q[1:0])
            2'd0:    load_byte = word_q[7:0];
            2'd1:    load_byte = word_q[15:8];
            2'd2:    load_byte = word_q[23:16];
            default: load_byte = word_q[31:24];
        endcase
        load_half = addr_q[1] ? word_q[31:16] : word_q[15:0];
        case (dmtype_q)
            3'b001:  load_ext = {{16{load_half[15]}}, load_half};
            3'b010:  load_ext = {16'h0000, load_half};
            3'b011:  load_ext = {{24{load_byte[7]}}, load_byte};
            3'b100:  load_ext = {24'h000000, load_byte};
            default: load_ext = word_q;
        endcase
    end

    assign cpu_rdata    = (state_q == DONE && !misalign_q) ? load_ext : 32'h0;
    assign cpu_misalign = (state_q == DONE) && misalign_q;
    assign cpu_stall    = (state_q == IDLE) ? cpu_req : (state_q != DONE);

    assign mem_req  = req_q;
    assign mem_addr = req_q ? {addr_q[AW-1:2], 2'b00} : '0;
`ifdef DM_RMW_EN
    assign mem_we    = req_q && (state_q == WR || state_q == RMW_WR);
    assign mem_be    = req_q ? 4'b1111 : 4'b0000;
    assign mem_wdata = mem_we ? merged_wdata : 32'h0;
`else
    assign mem_we    = req_q && (state_q == WR);
    assign mem_be    = req_q ? lane_be : 4'b0000;
    assign mem_wdata = mem_we ? steer_wdata : 32'h0;
`endif

endmodule

// File: tb/tb_dm_ctrl.sv
// Directed self-checking bench for dm_ctrl; expectations follow DM_RMW_EN when it is defined.
module tb_dm_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [2:0]  cpu_dmtype;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall, cpu_misalign;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;

    int checks   = 0;
    int failures = 0;

    dm_ctrl #(.AW(32)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_dmtype(cpu_dmtype),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall), .cpu_misalign(cpu_misalign),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    // Presents one access (caller sits just after a rising edge) and plays the memory:
    // acks once mem_req has been high for waits+1 cycles. Returns just after the edge leaving DONE
    // with cpu_req still high, so a following call is a back-to-back access.
    task automatic run_access(input logic we, input logic [2:0] dt, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] memword, input int waits,
                              output int stall_n, output int req_n, output int misal_n,
                              output logic [31:0] rdata, output logic [31:0] maddr,
                              output logic [31:0] mwdata, output logic [3:0] mbe,
                              output logic mwe, output logic to);
        int run;
        bit done;
        cpu_req = 1'b1; cpu_we = we; cpu_dmtype = dt; cpu_addr = addr; cpu_wdata = wdata;
        stall_n = 0; req_n = 0; misal_n = 0; run = 0; done = 0; to = 1'b0;
        rdata = '0; maddr = '0; mwdata = '0; mbe = '0; mwe = 1'b0;
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            @(negedge clk);
            if (cpu_misalign) misal_n++;
            if (!cpu_stall) begin
                rdata = cpu_rdata;
                done  = 1;
            end else begin
                stall_n++;
                if (mem_req) begin
                    run++; req_n++;
                    maddr = mem_addr; mbe = mem_be; mwe = mem_we;
                    if (mem_we) mwdata = mem_wdata;
                    mem_ack   = (run > waits);
                    mem_rdata = mem_ack ? memword : 32'h0BAD0BAD;
                end else begin
                    run = 0;
                    mem_ack = 1'b0;
                end
            end
            @(posedge clk); #1;
            mem_ack = 1'b0;
        end
        to = !done;
    endtask

    task automatic go_idle();
        cpu_req = 1'b0; cpu_we = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_dmtype = '0;
        cpu_addr = '0; cpu_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
        #12;
        checks++; if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== '0) begin failures++; $display("FAIL reset_mem: got req=%b we=%b be=%b addr=%h wd=%h, expected all 0", mem_req, mem_we, mem_be, mem_addr, mem_wdata); end
        checks++; if ({cpu_rdata, cpu_stall, cpu_misalign} !== '0) begin failures++; $display("FAIL reset_cpu: got rdata=%h stall=%b mis=%b, expected all 0", cpu_rdata, cpu_stall, cpu_misalign); end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if ({mem_req, cpu_stall, cpu_rdata} !== '0) begin failures++; $display("FAIL post_reset_idle: got req=%b stall=%b rdata=%h, expected 0", mem_req, cpu_stall, cpu_rdata); end
    endtask

    task automatic test_load_word();
        int s, r, m; logic [31:0] rd, ma, wd; logic [3:0] be; logic we, to;
        run_access(1'b0, 3'b000, 32'h100, 32'h0, 32'hDEADBEEF, 0, s, r, m, rd, ma, wd, be, we, to);
        checks++; if (to) begin failures++; $display("FAIL lw_timeout: got timeout, expected DONE"); end
        checks++; if (ma !== 32'h100) begin failures++; $display("FAIL lw_addr: got %h expected 00000100", ma); end
        checks++; if (s != 2) begin failures++; $display("FAIL lw_stall: got %0d expected 2", s); end
        checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_rdata: got %h expected deadbeef", rd); end
        checks++; if (we !== 1'b0 || r != 1) begin failures++; $display("FAIL lw_req: got we=%b reqcycles=%0d expected we=0 reqcycles=1", we, r); end
        go_idle();
    endtask

    task automatic test_load_ext();
        logic [2:0]  dt [4] = '{3'b011, 3'b100, 3'b001, 3'b010};
        logic [31:0] ad [4] = '{32'h103, 32'h103, 32'h102, 32'h100};
        logic [31:0] ex [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8011, 32'h00002233};
        int s, r, m; logic [31:0] rd, ma, wd; logic [3:0] be; logic we, to;
        for (int i = 0; i < 4; i++) begin
            run_access(1'b0, dt[i], ad[i], 32'h0, 32'h80112233, 1, s, r, m, rd, ma, wd, be, we, to);
            checks++; if (rd !== ex[i] || to) begin failures++; $display("FAIL load_ext[%0d]: got %h expected %h", i, rd, ex[i]); end
            checks++; if (s != 3 || m != 0) begin failures++; $display("FAIL load_ext_stall[%0d]: got stall=%0d mis=%0d expected stall=3 mis=0", i, s, m); end
            go_idle();
        end
    endtask

    task automatic test_store_half();
        int s, r, m; logic [31:0] rd, ma, wd; logic [3:0] be; logic we, to;
`ifdef DM_RMW_EN
        logic [3:0] e_be = 4'b1111; logic [31:0] e_wd = 32'hABCD3344; int e_s = 10, e_r = 8;
`else
        logic [3:0] e_be = 4'b1100; logic [31:0] e_wd = 32'hABCDABCD; int e_s = 5, e_r = 4;
`endif
        run_access(1'b1, 3'b001, 32'h102, 32'h0000ABCD, 32'h11223344, 3, s, r, m, rd, ma, wd, be, we, to);
        checks++; if (be !== e_be || we !== 1'b1) begin failures++; $display("FAIL sh_be_we: got be=%b we=%b expected be=%b we=1", be, we, e_be); end
        checks++; if (wd !== e_wd) begin failures++; $display("FAIL sh_wdata: got %h expected %h", wd, e_wd); end
        checks++; if (r != e_r || s != e_s || to) begin failures++; $display("FAIL sh_timing: got req=%0d stall=%0d expected req=%0d stall=%0d", r, s, e_r, e_s); end
        checks++; if (ma !== 32'h100) begin failures++; $display("FAIL sh_addr: got %h expected 00000100", ma); end
        go_idle();
    endtask

    task automatic test_store_byte_word();
        int s, r, m; logic [31:0] rd, ma, wd; logic [3:0] be; logic we, to;
`ifdef DM_RMW_EN
        logic [3:0] e_be = 4'b1111; logic [31:0] e_wd = 32'h11225A44; int e_s = 4;
`else
        logic [3:0] e_be = 4'b0010; logic [31:0] e_wd = 32'h5A5A5A5A; int e_s = 2;
`endif
        run_access(1'b1, 3'b011, 32'h101, 32'hFFFFFF5A, 32'h11223344, 0, s, r, m, rd, ma, wd, be, we, to);
        checks++; if (be !== e_be || wd !== e_wd) begin failures++; $display("FAIL sb: got be=%b wd=%h expected be=%b wd=%h", be, wd, e_be, e_wd); end
        checks++; if (s != e_s || to) begin failures++; $display("FAIL sb_stall: got %0d expected %0d", s, e_s); end
        go_idle();
        run_access(1'b1, 3'b000, 32'h200, 32'h12345678, 32'h0, 0, s, r, m, rd, ma, wd, be, we, to);
        checks++; if (be !== 4'b1111 || wd !== 32'h12345678 || ma !== 32'h200) begin failures++; $display("FAIL sw: got be=%b wd=%h addr=%h expected 1111 12345678 00000200", be, wd, ma); end
        checks++; if (s != 2 || r != 1) begin failures++; $display("FAIL sw_stall: got stall=%0d req=%0d expected 2 1", s, r); end
        go_idle();
    endtask

    task automatic test_misalign();
        logic        wv [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [2:0]  dt [4] = '{3'b000, 3'b001, 3'b000, 3'b111};
        logic [31:0] ad [4] = '{32'h101, 32'h103, 32'h102, 32'h102};
        int s, r, m; logic [31:0] rd, ma, wd; logic [3:0] be; logic we, to;
        for (int i = 0; i < 4; i++) begin
            run_access(wv[i], dt[i], ad[i], 32'hFFFFFFFF, 32'hFFFFFFFF, 0, s, r, m, rd, ma, wd, be, we, to);
            checks++; if (r != 0 || m != 1 || s != 1 || to) begin failures++; $display("FAIL misalign[%0d]: got req=%0d pulse=%0d stall=%0d expected 0 1 1", i, r, m, s); end
            checks++; if (rd !== 32'h0) begin failures++; $display("FAIL misalign_rdata[%0d]: got %h expected 00000000", i, rd); end
            go_idle();
        end
    endtask

    task automatic test_back_to_back();
        int s, r, m; logic [31:0] rd, ma, wd; logic [3:0] be; logic we, to;
        run_access(1'b0, 3'b000, 32'h300, 32'h0, 32'hCAFEF00D, 0, s, r, m, rd, ma, wd, be, we, to);
        checks++; if (rd !== 32'hCAFEF00D || r != 1 || to) begin failures++; $display("FAIL b2b_first: got rdata=%h req=%0d expected cafef00d 1", rd, r); end
        run_access(1'b0, 3'b100, 32'h301, 32'h0, 32'h0000A500, 2, s, r, m, rd, ma, wd, be, we, to);
        checks++; if (rd !== 32'h000000A5 || r != 3 || s != 4 || to) begin failures++; $display("FAIL b2b_second: got rdata=%h req=%0d stall=%0d expected 000000a5 3 4", rd, r, s); end
        go_idle();
    endtask

    task automatic test_reset_mid();
        int s, r, m; logic [31:0] rd, ma, wd; logic [3:0] be; logic we, to;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_dmtype = 3'b000; cpu_addr = 32'h100;
        @(negedge clk);
        @(negedge clk);
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL mid_req_up: got %b expected 1", mem_req); end
        #2 reset = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin failures++; $display("FAIL mid_req_drop: got req=%b addr=%h expected 0", mem_req, mem_addr); end
        cpu_req = 1'b0;
        #1;
        checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL mid_idle: got stall=%b expected 0", cpu_stall); end
        #4 reset = 1'b1;
        @(posedge clk); #1;
        run_access(1'b0, 3'b000, 32'h104, 32'h0, 32'h13579BDF, 0, s, r, m, rd, ma, wd, be, we, to);
        checks++; if (rd !== 32'h13579BDF || s != 2 || to) begin failures++; $display("FAIL mid_recover: got rdata=%h stall=%0d expected 13579bdf 2", rd, s); end
        go_idle();
    endtask

    task automatic test_stray_ack();
        mem_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (mem_req !== 1'b0 || cpu_stall !== 1'b0 || cpu_rdata !== 32'h0) begin failures++; $display("FAIL stray_ack: got req=%b stall=%b rdata=%h expected 0", mem_req, cpu_stall, cpu_rdata); end
        mem_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_load_ext();
        test_store_half();
        test_store_byte_word();
        test_misalign();
        test_back_to_back();
        test_reset_mid();
        test_stray_ack();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dm_ctrl.md
# dm_ctrl

Data-memory controller between the single-cycle RISC-V core's data port and a variable-latency, word-wide data memory with a req/ack handshake. It does the following:
- registers each load/store the core issues;
- stalls the core until the memory acknowledges;
- performs byte/halfword lane steering and load sign/zero extension;
- flags misaligned accesses.

## Interface
Parameters:
- AW, 32, byte-address width of cpu_addr/mem_addr

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- cpu_req  in  1  core issues a load or store this cycle
- cpu_we  in  1  1 = store, 0 = load (core mem_w)
- cpu_dmtype  in  3  000 word, 001 half, 010 half unsigned, 011 byte, 100 byte unsigned; 101–111 treated as word
- cpu_addr  in  AW  byte address (core ALU output)
- cpu_wdata  in  32  store data (core rs2 value)
- cpu_rdata  out  32  extended load data, valid while state = DONE
- cpu_stall  out  1  core must hold PC and register writes
- cpu_misalign  out  1  one-cycle pulse in DONE for a misaligned access
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write
- mem_be  out  4  byte enables, bit k = byte lane k
- mem_addr  out  AW  word address, bits [1:0] forced to 0
- mem_wdata  out  32  lane-steered write data
- mem_rdata  in  32  read word, valid when mem_ack = 1
- mem_ack  in  1  memory completes the current request at this edge

## Operation
- **States:** IDLE, RD, WR, DONE, plus RMW_RD and RMW_WR when DM_RMW_EN is defined.
- **IDLE, cpu_req = 1:**
  - Latch we, dmtype, addr and wdata.
  - If misaligned, go to DONE with the misalign flag set; otherwise go to RD (load) or WR (store).
- **Misaligned:** word with addr[1:0] ≠ 0; half with addr[0] ≠ 0.
- **RD / WR:** mem_req = 1. On mem_ack: RD captures mem_rdata into the read register; both states go to DONE.
- **DONE:** lasts one cycle, then IDLE. The core retires the instruction at the edge leaving DONE; the next instruction is presented in IDLE.
- **Lane steering on stores:**
  - Byte: be = 1 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - Half: be = addr[1] ? 1100 : 0011; wdata = {2{wdata[15:0]}}.
  - Word: be = 1111.
- **Load extraction:** byte lane addr[1:0] or half lane addr[1] of the captured word, sign- or zero-extended per dmtype.
- **Misaligned access:** no memory request is issued, stores are dropped, and cpu_rdata = 0.
- **Output values:**
  - cpu_stall = 1 in IDLE when cpu_req = 1, and in RD, WR, RMW_RD and RMW_WR; 0 in DONE and in IDLE with no request.
  - mem_* outputs are 0 outside the request states.

## Timing
- **Reset values:** state IDLE; cpu_rdata, mem_req, mem_we, mem_be, mem_addr, mem_wdata, cpu_misalign all 0; cpu_stall 0 (with cpu_req = 0).
- **Reset mid-transaction:** mem_req drops asynchronously and the transaction is abandoned. The memory must tolerate an unacknowledged request being withdrawn.
- **mem_req:** registered, rises the cycle after IDLE accepts. mem_addr, mem_we, mem_be and mem_wdata are stable while mem_req = 1.
- **Latency:** ack in the first request cycle → core stalled 2 cycles, retires in cycle 3. Each extra wait cycle adds 1.
- **Misaligned access:** IDLE → DONE, stall for 1 cycle.
- **Invariants:** mem_ack outside request states is ignored. cpu_req is ignored outside IDLE; the core holds it stable while stalled.
- **Back-to-back accesses:** IDLE accepts a new request the cycle after DONE. No request is lost or double-issued.

## Configuration
- **DM_RMW_EN undefined:** single-write stores as in Operation, using mem_be.
- **DM_RMW_EN defined:**
  - mem_be is always 1111, for a memory without byte enables.
  - Word stores use WR.
  - Sub-word stores go IDLE → RMW_RD (read word, wait ack) → RMW_WR, which writes the read word with the target lanes replaced by store data. RMW_WR waits for ack, then goes to DONE.
  - Minimum stall for a sub-word store is 4 cycles.

## Test plan
- **Load word:** lw, addr 0x100, mem_rdata 0xDEADBEEF, ack in first request cycle → mem_addr 0x100, stall 2 cycles, cpu_rdata 0xDEADBEEF in DONE.
- **Load byte, signed and unsigned:** lb at 0x103, word 0x80112233 → cpu_rdata 0xFFFFFF80. lbu at the same address → 0x00000080.
- **Store halfword with wait states:** sh at 0x102, wdata 0x0000ABCD, ack after 3 wait cycles → mem_be 1100, mem_wdata 0xABCDABCD, mem_we 1; mem_req held 4 cycles; stall 5 cycles.
- **Misaligned word load:** lw at 0x101 → no mem_req, cpu_misalign pulse 1 cycle, stall 1 cycle, cpu_rdata 0.
- **Reset mid-transaction:** assert reset during RD with no ack → mem_req 0 immediately, state IDLE; after release, the next lw completes normally.
- **RMW store (DM_RMW_EN defined):** sb 0x5A at 0x101, memory word 0x11223344 → read, then write 0x11225A44 with mem_be 1111.
